// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory port.
// Accepts one load/store at a time and answers with a one-cycle response
// pulse LATENCY clock edges after acceptance. While a request is in flight
// the stall output freezes the upstream pipeline stages.
// Optional build macro: DMEM_OOR_CHECK_EN enables the address-range check
// (upper address bits must be zero); without it upper bits simply wrap.
module dmem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

`ifdef DMEM_OOR_CHECK_EN
    // True when any address bit above the array index is set.
    function automatic logic addr_out_of_range(input logic [15:0] addr);
        return ((addr >> ADDR_W) != 16'd0);
    endfunction
`endif

    // Registered state
    state_t              state_r;
    logic [3:0]          cnt_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [15:0]         wdata_r;
    logic                oor_r;
    logic                resp_valid_r;
    logic                resp_we_r;
    logic [15:0]         resp_rdata_r;
    logic                resp_err_r;

    // Next-state values
    state_t              state_nx_s;
    logic [3:0]          cnt_nx_s;
    logic                we_nx_s;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic [15:0]         wdata_nx_s;
    logic                oor_nx_s;
    logic                resp_valid_nx_s;
    logic                resp_we_nx_s;
    logic [15:0]         resp_rdata_nx_s;
    logic                resp_err_nx_s;
    logic                mem_we_s;
    logic                req_oor_s;
    logic [15:0]         mem_rd_s;

    logic [15:0]         mem [DEPTH];

`ifdef DMEM_OOR_CHECK_EN
    assign req_oor_s = addr_out_of_range(req_addr);
`else
    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^(req_addr >> ADDR_W);
    assign req_oor_s        = 1'b0;
`endif

    assign mem_rd_s   = mem[addr_r];
    assign req_ready  = (state_r != ST_WAIT);
    assign stall      = req_valid & ~req_ready;
    assign resp_valid = resp_valid_r;
    assign resp_we    = resp_we_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Next-state logic: acceptance, latency countdown and response generation.
    always_comb begin
        state_nx_s      = state_r;
        cnt_nx_s        = cnt_r;
        we_nx_s         = we_r;
        addr_nx_s       = addr_r;
        wdata_nx_s      = wdata_r;
        oor_nx_s        = oor_r;
        resp_valid_nx_s = 1'b0;
        resp_we_nx_s    = resp_we_r;
        resp_rdata_nx_s = resp_rdata_r;
        resp_err_nx_s   = 1'b0;
        mem_we_s        = 1'b0;

        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (req_valid) begin
                    we_nx_s    = req_we;
                    addr_nx_s  = req_addr[ADDR_W-1:0];
                    wdata_nx_s = req_wdata;
                    oor_nx_s   = req_oor_s;
                    cnt_nx_s   = CNT_LOAD;
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s      = ST_RESP;
                    resp_valid_nx_s = 1'b1;
                    resp_we_nx_s    = we_r;
                    resp_err_nx_s   = oor_r;
                    if (we_r) begin
                        // Store commits on the response edge; rdata keeps the last load.
                        mem_we_s = ~oor_r;
                    end else if (oor_r) begin
                        resp_rdata_nx_s = 16'h0000;
                    end else begin
                        resp_rdata_nx_s = mem_rd_s;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= 16'h0000;
            oor_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_we_r    <= 1'b0;
            resp_rdata_r <= 16'h0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            we_r         <= we_nx_s;
            addr_r       <= addr_nx_s;
            wdata_r      <= wdata_nx_s;
            oor_r        <= oor_nx_s;
            resp_valid_r <= resp_valid_nx_s;
            resp_we_r    <= resp_we_nx_s;
            resp_rdata_r <= resp_rdata_nx_s;
            resp_err_r   <= resp_err_nx_s;
        end
    end

    // Storage array write port; reset blocks a pending store from committing.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem[addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected responses
// (cycle, we, rdata, err) into a queue; a monitor pops and compares on every
// resp_valid pulse.
module tb_dmem_responder;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic        resp_we;
    logic [15:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model [int];
    logic [15:0] exp_rdata;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          st;

    // Edge counter used to time responses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid@%0d required=none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_we", int'(resp_we), int'(e.we));
                chk("resp_rdata", int'(resp_rdata), int'(e.rdata));
                chk("resp_err", int'(resp_err), int'(e.err));
            end
        end
    end

    // Present a request and hold it until accepted; returns cycles spent stalled.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input bit expect_resp, output int stalls);
        int   budget;
        int   idx;
        logic oor;
        exp_t e;
        budget = 0;
        stalls = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && budget < 50) begin
            if (stall) stalls++;
            @(posedge clk);
            #1;
            budget++;
        end
        chk("req_accepted", int'(req_ready), 1);
        idx = int'(addr) % (2 ** AW);
`ifdef DMEM_OOR_CHECK_EN
        oor = (addr >> AW) != 16'd0;
`else
        oor = 1'b0;
`endif
        e.cyc = cyc + 1 + LAT;
        e.we  = we;
        e.err = oor;
        if (expect_resp) begin
            if (we) begin
                if (!oor) model[idx] = wdata;
            end else if (oor) begin
                exp_rdata = 16'h0000;
            end else begin
                exp_rdata = model.exists(idx) ? model[idx] : 16'h0000;
            end
            e.rdata = exp_rdata;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) until all expected responses have arrived.
    task automatic drain();
        int budget;
        budget = 0;
        req_valid = 1'b0;
        while (sb_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        exp_rdata = 16'h0000;

        // Reset held two cycles with a request pending.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_stall", int'(stall), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_we", int'(resp_we), 0);
        chk("rst_resp_rdata", int'(resp_rdata), 16'h0000);
        chk("rst_resp_err", int'(resp_err), 0);
        rst = 1'b0;
        idle(2);
        chk("idle_no_resp", sb_q.size(), 0);

        // Store then load same address.
        issue(1'b1, 16'h0010, 16'h1234, 1'b1, st);
        chk("store_idle_stalls", st, 0);
        issue(1'b0, 16'h0010, 16'h0000, 1'b1, st);
        chk("load_stalls", st, LAT);
        drain();

        // Back-to-back stream with req_valid held high.
        issue(1'b1, 16'h0001, 16'hAAAA, 1'b1, st);
        issue(1'b1, 16'h0002, 16'h5555, 1'b1, st);
        chk("b2b_store_stalls", st, LAT);
        issue(1'b0, 16'h0001, 16'h0000, 1'b1, st);
        issue(1'b0, 16'h0002, 16'h0000, 1'b1, st);
        chk("b2b_load_stalls", st, LAT);
        drain();

        // Reset in the middle of a store: nothing commits, no response.
        issue(1'b1, 16'h0020, 16'h0000, 1'b1, st);
        drain();
        issue(1'b1, 16'h0020, 16'hBEEF, 1'b0, st);
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rdata = 16'h0000;
        chk("midrst_ready", int'(req_ready), 1);
        idle(LAT + 2);
        issue(1'b0, 16'h0020, 16'h0000, 1'b1, st);
        drain();

        // Upper address bits: wrap or range error depending on build.
        issue(1'b1, 16'h0005, 16'h0000, 1'b1, st);
        issue(1'b1, 16'h1005, 16'h7777, 1'b1, st);
        issue(1'b0, 16'h0005, 16'h0000, 1'b1, st);
        issue(1'b0, 16'h1005, 16'h0000, 1'b1, st);
        issue(1'b0, 16'h0010, 16'h0000, 1'b1, st);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
